// File: rtl/demux1to4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demultiplexer and its channel FIFOs.
package demux1to4_buf_pkg;

  localparam int NUM_CH   = 4;  // number of output channels
  localparam int DEPTH    = 2;  // words buffered per channel
  localparam int CH_IDX_W = 2;  // width of a channel index
  localparam int PTR_W    = 1;  // FIFO pointer width, wraps modulo DEPTH
  localparam int CNT_W    = 2;  // occupancy width, holds 0..DEPTH

endpackage

// File: rtl/demux1to4_buf_chan.sv
// Two-entry FIFO for one demux channel. The head word lives in its own
// register so it is a clean flop output and keeps its last value when empty.
module demux_chan_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = head_q;

  // A full FIFO refuses a push even when it is popped the same cycle;
  // popping an empty FIFO is ignored.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, pointers, occupancy and the registered head word.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Head changes only when a new word becomes the oldest one held:
    // push into empty, pop with a second word behind, or push+pop at one.
    if (empty_o && do_push) begin
      head_d = data_i;
    end else if (do_pop && full_o) begin
      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
    end else if (do_pop && do_push) begin
      head_d = data_i;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/demux1to4_buf.sv
// 1-to-4 demultiplexer with a two-word buffer per output channel.
//
// Handshake: a word moves across an interface exactly at a rising edge where
// its valid and ready are both high. Input side: in_ready depends only on the
// registered occupancy of channel in_sel, never on out_ready; the source holds
// in_sel/in_data stable until accepted. Output side: out_valid[i] is high
// whenever channel i holds a word; out_ready[i] with out_valid[i] low is ignored.
module demux1to4_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_IDX_W-1:0]     in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    busy
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  assign in_ready  = ~full[in_sel];
  assign out_valid = ~empty;
  assign pop       = out_ready & out_valid;
  assign busy      = |out_valid;

  // Decode the accepted input word to a one-hot push for its channel.
  always_comb begin
    push = '0;
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_buf #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push[g]),
      .data_i  (in_data),
      .pop_i   (pop[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .head_o  (out_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: directed scenarios plus random traffic, checked
// against per-channel queues that model the buffered demux behaviour.
module tb_demux1to4_buf;

  localparam int W  = 8;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sel;
  logic [W-1:0]  in_data;
  logic [NC-1:0] out_valid;
  logic [NC-1:0] out_ready;
  logic [NC*W-1:0] out_data;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words held per channel, the word each channel last showed,
  // and words observed leaving the DUT.
  logic [W-1:0] exp_q [NC][$];
  logic [W-1:0] shown [NC];
  logic [W-1:0] got_q [NC][$];

  demux1to4_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      exp_q[i].delete();
      shown[i] = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NC-1:0]   ev;
    logic [NC*W-1:0] ed;
    for (int i = 0; i < NC; i++) begin
      ev[i]        = (exp_q[i].size() != 0);
      ed[i*W +: W] = shown[i];
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".busy"}, 64'(busy), 64'(|ev));
    check({tag, ".out_data"}, 64'(out_data), 64'(ed));
  endtask

  // One clock cycle: drive inputs (called just after a falling edge), check
  // in_ready, log words leaving, apply the edge to the model, check outputs.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [W-1:0] data,
                       input logic [NC-1:0] ordy, input string tag, output logic acc);
    logic          do_push;
    logic [NC-1:0] do_pop;
    in_valid  = v;
    in_sel    = sel;
    in_data   = data;
    out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_q[sel].size() < 2));
    for (int i = 0; i < NC; i++) begin
      if (out_valid[i] && ordy[i]) got_q[i].push_back(out_data[i*W +: W]);
    end
    do_push = v && (exp_q[sel].size() < 2);
    for (int i = 0; i < NC; i++) do_pop[i] = ordy[i] && (exp_q[i].size() != 0);
    acc = do_push;
    @(posedge clk);
    for (int i = 0; i < NC; i++) begin
      if (do_pop[i]) void'(exp_q[i].pop_front());
    end
    if (do_push) exp_q[sel].push_back(data);
    for (int i = 0; i < NC; i++) begin
      if (exp_q[i].size() != 0) shown[i] = exp_q[i][0];
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input logic [NC-1:0] ordy);
    logic acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 2'd0, '0, ordy, "idle", acc);
  endtask

  initial begin
    logic acc;
    logic [W-1:0] d;
    logic [W-1:0] e;

    // Reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Single push to channel 2
    cycle(1'b1, 2'd2, 8'hA5, 4'b0000, "push_ch2", acc);
    check("push_ch2.acc", 64'(acc), 64'(1));
    check("push_ch2.valid", 64'(out_valid), 64'(4'b0100));
    check("push_ch2.data", 64'(out_data), 64'(32'h00A5_0000));
    idle(1, 4'b0100);

    // Channel 1 fills, refuses a third word, then drains in order
    cycle(1'b1, 2'd1, 8'h11, 4'b0000, "fill1_a", acc);
    cycle(1'b1, 2'd1, 8'h22, 4'b0000, "fill1_b", acc);
    cycle(1'b1, 2'd1, 8'h33, 4'b0000, "fill1_c", acc);
    check("fill1_c.refused", 64'(acc), 64'(0));
    cycle(1'b1, 2'd1, 8'h33, 4'b0010, "drain1_a", acc);
    check("drain1_a.refused", 64'(acc), 64'(0));
    check("drain1_a.head", 64'(out_data[15:8]), 64'(8'h22));
    cycle(1'b1, 2'd1, 8'h33, 4'b0010, "drain1_b", acc);
    check("drain1_b.acc", 64'(acc), 64'(1));
    check("drain1_b.head", 64'(out_data[15:8]), 64'(8'h33));
    idle(2, 4'b1111);
    check("drain1.log_len", 64'(got_q[1].size()), 64'(3));
    if (got_q[1].size() == 3) begin
      check("drain1.w0", 64'(got_q[1][0]), 64'(8'h11));
      check("drain1.w1", 64'(got_q[1][1]), 64'(8'h22));
      check("drain1.w2", 64'(got_q[1][2]), 64'(8'h33));
    end

    // Channel 3: full with push+pop refuses, then occupancy-1 push+pop
    cycle(1'b1, 2'd3, 8'hA1, 4'b0000, "fill3_a", acc);
    cycle(1'b1, 2'd3, 8'hA2, 4'b0000, "fill3_b", acc);
    cycle(1'b1, 2'd3, 8'h44, 4'b1000, "full3_pp", acc);
    check("full3_pp.refused", 64'(acc), 64'(0));
    check("full3_pp.head", 64'(out_data[31:24]), 64'(8'hA2));
    cycle(1'b1, 2'd3, 8'h44, 4'b1000, "one3_pp", acc);
    check("one3_pp.acc", 64'(acc), 64'(1));
    check("one3_pp.valid", 64'(out_valid), 64'(4'b1000));
    check("one3_pp.head", 64'(out_data[31:24]), 64'(8'h44));
    idle(2, 4'b1111);
    check("empty3.holds_last", 64'(out_data[31:24]), 64'(8'h44));

    // Round-robin pushes with all sinks ready
    for (int i = 0; i < NC; i++) got_q[i].delete();
    for (int k = 0; k < 16; k++) begin
      d = W'(k);
      cycle(1'b1, d[1:0], d, 4'b1111, "rr", acc);
      check("rr.acc", 64'(acc), 64'(1));
    end
    idle(3, 4'b1111);
    for (int c = 0; c < NC; c++) begin
      check("rr.count", 64'(got_q[c].size()), 64'(4));
      for (int j = 0; j < 4 && j < got_q[c].size(); j++) begin
        e = W'(c + 4 * j);
        check("rr.word", 64'(got_q[c][j]), 64'(e));
      end
    end

    // Asynchronous reset with words in every channel
    for (int c = 0; c < NC; c++) begin
      cycle(1'b1, 2'(c), W'(8'hC0 + c), 4'b0000, "prefill", acc);
    end
    check("prefill.busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.valid", 64'(out_valid), 64'(0));
    check("async_rst.busy", 64'(busy), 64'(0));
    check("async_rst.data", 64'(out_data), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 2'd0, 8'h5A, 4'b0000, "post_rst", acc);
    check("post_rst.acc", 64'(acc), 64'(1));
    check("post_rst.valid", 64'(out_valid), 64'(4'b0001));
    check("post_rst.data", 64'(out_data), 64'(32'h0000_005A));

    // Random traffic; a refused word is held until accepted
    begin
      logic       pend_v = 1'b0;
      logic [1:0] pend_s = '0;
      logic [W-1:0] pend_d = '0;
      for (int k = 0; k < 600; k++) begin
        if (!pend_v && ($urandom_range(0, 3) != 0)) begin
          pend_v = 1'b1;
          pend_s = 2'($urandom_range(0, 3));
          pend_d = W'($urandom);
        end
        cycle(pend_v, pend_s, pend_d, 4'($urandom), "rand", acc);
        if (acc) pend_v = 1'b0;
      end
    end
    idle(4, 4'b1111);
    check("final.busy", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
